// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding IMEM read at a time feeding a 2-entry instruction buffer.
// Define FETCH_MISALIGN_CHK_EN to reject misaligned redirect targets instead of force-aligning them.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        pcsrc,
    input  logic [31:0] pctarget,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready,
    output logic        fetch_misalign
);
    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, KILL} state_t;

    state_t          state;
    state_t          state_nxt;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] req_addr;
    logic [XLEN-1:0] buf_instr [2];
    logic [XLEN-1:0] buf_pc    [2];
    logic            rd_ptr;
    logic            wr_ptr;
    logic [1:0]      count;

    logic [XLEN-1:0] target_c;
    logic            redirect_c;
    logic            misalign_c;
    logic            issue_c;
    logic            push_c;
    logic            pop_c;

    // Redirect qualification; IDLE never honours a redirect
`ifdef FETCH_MISALIGN_CHK_EN
    assign misalign_c = pcsrc && (state != IDLE) && (pctarget[1:0] != 2'b00);
    assign redirect_c = pcsrc && (state != IDLE) && (pctarget[1:0] == 2'b00);
    assign target_c   = pctarget;
`else
    assign misalign_c = 1'b0;
    assign redirect_c = pcsrc && (state != IDLE);
    assign target_c   = pctarget & ~XLEN'(3);
`endif

    assign issue_c = (state == ISSUE) && (count < 2'd2) && !redirect_c;
    assign push_c  = (state == WAIT) && imem_rvalid && !redirect_c;
    assign pop_c   = instr_valid && instr_ready && !redirect_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a response seen in KILL retires the killed request
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = ISSUE;
            ISSUE:   if (issue_c) state_nxt = WAIT;
            WAIT: begin
                if (imem_rvalid) begin
                    state_nxt = ISSUE;
                end else if (redirect_c) begin
                    state_nxt = KILL;
                end
            end
            KILL:    if (imem_rvalid) state_nxt = ISSUE;
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        imem_req    = issue_c;
        imem_addr   = issue_c ? pc : '0;
        instr_valid = (count != 2'd0);
        instr       = instr_valid ? buf_instr[rd_ptr] : NOP;
        instr_pc    = instr_valid ? buf_pc[rd_ptr] : '0;
    end

    // PC, instruction buffer and misalign pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_PC;
            req_addr       <= '0;
            buf_instr[0]   <= '0;
            buf_instr[1]   <= '0;
            buf_pc[0]      <= '0;
            buf_pc[1]      <= '0;
            rd_ptr         <= 1'b0;
            wr_ptr         <= 1'b0;
            count          <= 2'd0;
            fetch_misalign <= 1'b0;
        end else begin
            fetch_misalign <= misalign_c;
            if (redirect_c) begin
                pc <= target_c;
            end else if (issue_c) begin
                pc       <= pc + XLEN'(4);
                req_addr <= pc;
            end
            if (redirect_c) begin
                rd_ptr <= 1'b0;
                wr_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (push_c) begin
                    buf_instr[wr_ptr] <= imem_rdata;
                    buf_pc[wr_ptr]    <= req_addr;
                    wr_ptr            <= ~wr_ptr;
                end
                if (pop_c) begin
                    rd_ptr <= ~rd_ptr;
                end
                count <= count + 2'(push_c) - 2'(pop_c);
            end
        end
    end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized traffic against a stream-level model
// (delivered PCs run sequentially from the last redirect target, data is a fixed function of address).
module tb_fetch_unit;
    localparam logic [31:0] NOP   = 32'h0000_0013;
    localparam logic [31:0] HI_PC = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req, imem_rvalid, pcsrc, instr_valid, instr_ready, fetch_misalign;
    logic [31:0] imem_addr, imem_rdata, pctarget, instr, instr_pc;
    logic        hi_req, hi_valid, hi_mis;
    logic [31:0] hi_addr, hi_instr, hi_pc;

    fetch_unit u_dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pcsrc(pcsrc), .pctarget(pctarget),
        .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
        .instr_ready(instr_ready), .fetch_misalign(fetch_misalign)
    );

    fetch_unit #(.RESET_PC(HI_PC)) u_dut_hi (
        .clk(clk), .rst_n(rst_n), .imem_req(hi_req), .imem_addr(hi_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .pcsrc(pcsrc), .pctarget(pctarget),
        .instr_valid(hi_valid), .instr(hi_instr), .instr_pc(hi_pc),
        .instr_ready(instr_ready), .fetch_misalign(hi_mis)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    int          cyc;
    int          resp_due;
    int          lat_lo, lat_hi;
    int          total_acc;
    logic [31:0] resp_addr;
    bit          fixed_data;
    bit          outstanding;
    bit          exp_flush, exp_mis;
    logic [31:0] exp_pc, exp_req;
    logic [31:0] req_log[$];
    logic [31:0] acc_log[$];
    logic [31:0] hi_log[$];
    logic        s_req, s_valid, s_mis;
    logic [31:0] s_addr, s_pc;

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return fixed_data ? 32'h0050_0093 : ({a[15:0], ~a[31:16]} ^ 32'h1357_9BDF);
    endfunction

    function automatic logic [31:0] qget(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    // One clock cycle: check outputs mid-cycle, advance the model, then play the memory side
    task automatic tick();
        bit redir, acc;
        @(negedge clk);
        if (rst_n) cyc++;
        s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid; s_pc = instr_pc;
        s_mis = fetch_misalign;
        redir = rst_n && pcsrc && (cyc >= 2);
`ifdef FETCH_MISALIGN_CHK_EN
        chk1("misalign", fetch_misalign, exp_mis);
        exp_mis = redir && (pctarget[1:0] != 2'b00);
        if (pctarget[1:0] != 2'b00) redir = 1'b0;
`else
        chk1("misalign", fetch_misalign, 1'b0);
`endif
        if (instr_valid !== 1'b1) begin
            chk32("nop_instr", instr, NOP);
            chk32("nop_pc", instr_pc, 32'h0);
        end else begin
            chk32("head_pc", instr_pc, exp_pc);
            chk32("head_data", instr, memfn(instr_pc));
        end
        if (exp_flush) chk1("flushed", instr_valid, 1'b0);
        exp_flush = redir;
        if (!rst_n) begin
            chk1("rst_hi_req", hi_req, 1'b0);
            chk32("rst_hi_addr", hi_addr, 32'h0);
            chk1("rst_hi_valid", hi_valid, 1'b0);
            chk32("rst_hi_instr", hi_instr, NOP);
            chk32("rst_hi_pc", hi_pc, 32'h0);
            chk1("rst_hi_mis", hi_mis, 1'b0);
        end
        acc = (instr_valid === 1'b1) && instr_ready && !redir;
        if (acc) begin
            acc_log.push_back(instr_pc);
            exp_pc = exp_pc + 32'd4;
        end
        if (imem_rvalid) outstanding = 1'b0;
        if (imem_req === 1'b1) begin
            chk1("one_outstanding", outstanding, 1'b0);
            chk32("req_addr", imem_addr, exp_req);
            chk1("req_on_redirect", redir, 1'b0);
            req_log.push_back(imem_addr);
            exp_req     = exp_req + 32'd4;
            outstanding = 1'b1;
            resp_addr   = imem_addr;
            resp_due    = int'($urandom_range(lat_hi, lat_lo)) - 1;
        end else begin
            chk32("addr_idle", imem_addr, 32'h0);
        end
        if (hi_req === 1'b1) hi_log.push_back(hi_addr);
        if (redir) begin
            exp_pc  = pctarget & ~32'd3;
            exp_req = exp_pc;
        end
        @(posedge clk);
        #1;
        pcsrc = 1'b0;
        if (resp_due == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = memfn(resp_addr);
            resp_due    = -1;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (resp_due > 0) resp_due--;
        end
    endtask

    // Reset for three cycles; optionally present a stray response in the first cycle after release
    task automatic do_reset(input bit stray);
        rst_n = 1'b0;
        pcsrc = 1'b0;
        cyc = 0; outstanding = 1'b0; exp_flush = 1'b0; exp_mis = 1'b0;
        exp_pc = 32'h0; exp_req = 32'h0;
        total_acc += acc_log.size();
        req_log.delete(); acc_log.delete(); hi_log.delete();
        repeat (3) tick();
        rst_n = 1'b1;
        if (stray) begin
            imem_rvalid = 1'b1;
            imem_rdata  = 32'hBADC_0DE5;
        end
    endtask

    initial begin
        rst_n = 1'b0; pcsrc = 1'b0; pctarget = 32'h0; instr_ready = 1'b1;
        imem_rvalid = 1'b0; imem_rdata = 32'h0; resp_due = -1; resp_addr = 32'h0;
        lat_lo = 1; lat_hi = 1; fixed_data = 1'b1; total_acc = 0; cyc = 0;
        outstanding = 1'b0; exp_flush = 1'b0; exp_mis = 1'b0; exp_pc = 32'h0; exp_req = 32'h0;

        // Back-to-back fetch with 1-cycle memory, decode always ready
        do_reset(1'b1);
        tick(); chk1("idle_no_req", s_req, 1'b0);
        tick(); chk1("first_req_c2", s_req, 1'b1); chk32("first_addr", s_addr, 32'h0);
        tick(); chk1("c3_not_valid", s_valid, 1'b0);
        tick(); chk1("c4_valid", s_valid, 1'b1);
        repeat (8) tick();
        chk32("req0", qget(req_log, 0), 32'h0);
        chk32("req1", qget(req_log, 1), 32'h4);
        chk32("req2", qget(req_log, 2), 32'h8);
        chk32("acc0", qget(acc_log, 0), 32'h0);
        chk32("acc1", qget(acc_log, 1), 32'h4);
        chk32("acc2", qget(acc_log, 2), 32'h8);
        chk32("hi_req0", qget(hi_log, 0), 32'hFFFF_FFF8);
        chk32("hi_req1", qget(hi_log, 1), 32'hFFFF_FFFC);
        chk32("hi_req2", qget(hi_log, 2), 32'h0000_0000);

        // Decode stalled: buffer fills with two entries and fetch stops
        fixed_data = 1'b0; instr_ready = 1'b0;
        do_reset(1'b0);
        repeat (12) tick();
        chk32("stall_reqs", 32'(req_log.size()), 32'd2);
        chk32("stall_req1", qget(req_log, 1), 32'h4);
        chk1("stall_valid", s_valid, 1'b1);
        chk32("stall_pc", s_pc, 32'h0);
        instr_ready = 1'b1;
        repeat (10) tick();
        chk32("drain0", qget(acc_log, 0), 32'h0);
        chk32("drain1", qget(acc_log, 1), 32'h4);
        chk32("after_drain_req", qget(req_log, 2), 32'h8);

        // Redirect while waiting; the late response must be discarded
        lat_lo = 4; lat_hi = 4;
        do_reset(1'b0);
        tick(); tick();
        pcsrc = 1'b1; pctarget = 32'h0000_0100;
        tick();
        tick(); chk1("kill_noreq_c4", s_req, 1'b0);
        tick(); chk1("kill_noreq_c5", s_req, 1'b0);
        tick(); chk1("kill_noreq_c6", s_req, 1'b0);
        tick(); chk1("kill_req_c7", s_req, 1'b1); chk32("kill_addr", s_addr, 32'h100);
        chk1("kill_no_valid", s_valid, 1'b0);
        chk32("kill_no_acc", 32'(acc_log.size()), 32'd0);
        repeat (6) tick();
        chk32("kill_first_acc", qget(acc_log, 0), 32'h100);

        // Redirect in the response cycle with one entry buffered
        lat_lo = 1; lat_hi = 1; instr_ready = 1'b0;
        do_reset(1'b0);
        repeat (4) tick();
        chk1("same_pre_valid", s_valid, 1'b1);
        pcsrc = 1'b1; pctarget = 32'h0000_0200;
        tick();
        tick(); chk1("same_req", s_req, 1'b1); chk32("same_addr", s_addr, 32'h200);
        chk1("same_flushed", s_valid, 1'b0);
        instr_ready = 1'b1;
        repeat (4) tick();

        // Misaligned redirect target
        do_reset(1'b0);
        repeat (3) tick();
        pcsrc = 1'b1; pctarget = 32'h0000_0102;
        tick();
`ifdef FETCH_MISALIGN_CHK_EN
        chk1("mis_ignored_req", s_req, 1'b1); chk32("mis_ignored_addr", s_addr, 32'h4);
        tick(); chk1("mis_pulse", s_mis, 1'b1);
        tick(); chk1("mis_pulse_end", s_mis, 1'b0);
`else
        chk1("mis_noreq", s_req, 1'b0);
        tick(); chk1("mis_req", s_req, 1'b1); chk32("mis_aligned_addr", s_addr, 32'h100);
        chk1("mis_tied", s_mis, 1'b0);
        tick();
`endif

        // Randomized traffic with mid-transaction resets
        lat_lo = 1; lat_hi = 3; total_acc = 0;
        for (int seg = 0; seg < 3; seg++) begin
            do_reset(seg[0]);
            for (int n = 0; n < 600; n++) begin
                instr_ready = ($urandom_range(9) < 7);
                if (cyc >= 1 && $urandom_range(15) == 0) begin
                    pcsrc    = 1'b1;
                    pctarget = $urandom;
`ifdef FETCH_MISALIGN_CHK_EN
                    pctarget[1:0] = 2'b00;
`endif
                end
                tick();
            end
        end
        total_acc += acc_log.size();
        chk1("progress", total_acc > 100, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
